// File: rtl/shared_pkg.sv
// Types and constants shared by the SPI slave front end and the single-port RAM.
package shared_pkg;

    localparam int MEM_WIDTH = 8;
    localparam int CMD_WIDTH = MEM_WIDTH + 2;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam logic [3:0] BIT_CNT_LAST = 4'd9;
    localparam logic [3:0] BIT_CNT_SAT  = 4'd10;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

endpackage

// File: rtl/spi_miso_piso.sv
// MISO serialiser: loads one RAM word, drives it MSB-first over 8 edges, then pulses done.
module spi_miso_piso
    import shared_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic [MEM_WIDTH-1:0] load_data_i,
    output logic                 miso_o,
    output logic                 done_o
);

    logic [MEM_WIDTH-1:0] shift_q;
    logic [2:0]           cnt_q;
    logic                 busy_q;
    logic                 miso_q;
    logic                 done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr_i) begin
                shift_q <= '0;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
                miso_q  <= 1'b0;
            end else if (load_i) begin
                // MSB goes out on the load edge itself; the remaining 7 bits follow.
                shift_q <= load_data_i;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                miso_q  <= load_data_i[MEM_WIDTH-1];
            end else if (busy_q) begin
                if (cnt_q == 3'd7) begin
                    shift_q <= '0;
                    busy_q  <= 1'b0;
                    miso_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    miso_q  <= shift_q[MEM_WIDTH-2];
                    shift_q <= {shift_q[MEM_WIDTH-2:0], 1'b0};
                    cnt_q   <= cnt_q + 3'd1;
                end
            end
        end
    end

    assign miso_o = miso_q;
    assign done_o = done_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises MOSI frames into RAM commands and returns
// read data on MISO. clk doubles as SCK.
module spi_slave_ctrl
    import shared_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [MEM_WIDTH+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [MEM_WIDTH-1:0] tx_data,
    input  logic                 tx_valid
);

    spi_state_e           state_q;
    logic [3:0]           bit_cnt_q;
    logic [CMD_WIDTH-2:0] rx_shift_q;
    logic [CMD_WIDTH-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rd_addr_seen_q;
    logic                 tx_started_q;
    logic                 tx_load;
    logic                 piso_done;

    // One reply per READ_DATA frame, only after the command word has been handed over.
    assign tx_load = !SS_n && (state_q == READ_DATA) && (bit_cnt_q == BIT_CNT_SAT)
                     && tx_valid && !tx_started_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_started_q   <= 1'b0;
        end else begin
            // NOTE: defaulting the strobe low first makes rx_valid a single-cycle pulse
            // without repeating the clear in every branch.
            rx_valid_q <= 1'b0;
            if (piso_done) begin
                rd_addr_seen_q <= 1'b0;
            end
            if (SS_n) begin
                state_q      <= IDLE;
                bit_cnt_q    <= '0;
                tx_started_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= CHK_CMD;
                    CHK_CMD: begin
                        bit_cnt_q <= '0;
                        if (!MOSI)               state_q <= WRITE;
                        else if (rd_addr_seen_q) state_q <= READ_DATA;
                        else                     state_q <= READ_ADD;
                    end
                    default: begin
                        if (bit_cnt_q < BIT_CNT_SAT) begin
                            rx_shift_q <= {rx_shift_q[CMD_WIDTH-3:0], MOSI};
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == BIT_CNT_LAST) begin
                                rx_data_q  <= {rx_shift_q, MOSI};
                                rx_valid_q <= 1'b1;
                                if (state_q == READ_ADD) begin
                                    rd_addr_seen_q <= 1'b1;
                                end
                            end
                        end
                        if (tx_load) begin
                            tx_started_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    spi_miso_piso u_piso (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (SS_n),
        .load_i      (tx_load),
        .load_data_i (tx_data),
        .miso_o      (MISO),
        .done_o      (piso_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl with a scoreboard for command words and MISO bits.
module tb_spi_slave_ctrl;
    import shared_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int total = 0;
    int bad = 0;
    int rx_pulses = 0;
    logic [9:0] rx_exp[$];
    logic       miso_exp[$];

    spi_slave_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the result of the previous posedge; consume scoreboard entries as outputs appear.
    task automatic step();
        @(negedge clk);
        if (rx_valid === 1'b1) begin
            rx_pulses++;
            if (rx_exp.size() == 0) check("rx_valid_unexpected", rx_valid, 0);
            else                    check("rx_data", rx_data, rx_exp.pop_front());
        end
        if (miso_exp.size() > 0) check("miso_bit", MISO, miso_exp.pop_front());
        else                     check("miso_idle", MISO, 0);
    endtask

    task automatic send_frame(input logic sel, input logic [9:0] word, input spi_state_e exp_state);
        int p0;
        p0 = rx_pulses;
        rx_exp.push_back(word);
        SS_n = 1'b0;
        step();
        check("state_chk_cmd", dut.state_q, CHK_CMD);
        MOSI = sel;
        step();
        check("state_select", dut.state_q, exp_state);
        for (int i = 9; i >= 0; i--) begin
            MOSI = word[i];
            step();
        end
        check("rx_valid_at_last_bit", rx_valid, 1);
        check("rx_pulse_count", rx_pulses - p0, 1);
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        step();
        check("state_idle_after_frame", dut.state_q, IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        logic [7:0] rd_word;

        // Reset state
        #2;
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_miso", MISO, 0);
        check("rst_state", dut.state_q, IDLE);
        check("rst_rd_addr_seen", dut.rd_addr_seen_q, 0);
        check("rst_tx_shift", dut.u_piso.shift_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();

        // Write address
        send_frame(1'b0, 10'h0A5, WRITE);
        end_frame();

        // Write data, SS_n held low afterwards: no second pulse
        send_frame(1'b0, 10'h13C, WRITE);
        p = rx_pulses;
        repeat (5) begin
            MOSI = ~MOSI;
            step();
        end
        check("no_second_pulse", rx_pulses - p, 0);
        end_frame();

        // Read address then read data
        send_frame(1'b1, 10'h207, READ_ADD);
        end_frame();
        check("rd_addr_seen_set", dut.rd_addr_seen_q, 1);
        send_frame(1'b1, 10'h3E5, READ_DATA);
        rd_word = 8'hC3;
        tx_data = rd_word;
        tx_valid = 1'b1;
        for (int i = 7; i >= 0; i--) miso_exp.push_back(rd_word[i]);
        step();
        tx_valid = 1'b0;
        tx_data = 8'h00;
        repeat (7) step();
        check("miso_bits_consumed", miso_exp.size(), 0);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        repeat (3) step();
        tx_valid = 1'b0;
        check("rd_addr_seen_cleared", dut.rd_addr_seen_q, 0);
        end_frame();

        // Abort a READ_ADD frame after 6 bits
        p = rx_pulses;
        SS_n = 1'b0;
        step();
        MOSI = 1'b1;
        step();
        check("abort_state_read_add", dut.state_q, READ_ADD);
        for (int i = 0; i < 6; i++) begin
            MOSI = i[0];
            step();
        end
        SS_n = 1'b1;
        step();
        check("abort_state_idle", dut.state_q, IDLE);
        check("abort_no_rx_valid", rx_pulses - p, 0);
        check("abort_rd_addr_seen", dut.rd_addr_seen_q, 0);
        step();
        send_frame(1'b1, 10'h2AA, READ_ADD);
        end_frame();
        check("rd_addr_seen_after_abort", dut.rd_addr_seen_q, 1);

        // Stray tx_valid in IDLE and during WRITE
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        repeat (3) step();
        check("stray_idle_state", dut.state_q, IDLE);
        send_frame(1'b0, 10'h0F0, WRITE);
        end_frame();
        tx_valid = 1'b0;
        check("stray_rd_addr_seen", dut.rd_addr_seen_q, 1);

        // Asynchronous reset in the middle of a WRITE frame
        p = rx_pulses;
        SS_n = 1'b0;
        step();
        MOSI = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            MOSI = ~i[0];
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rx_data", rx_data, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_miso", MISO, 0);
        check("midrst_state", dut.state_q, IDLE);
        check("midrst_bit_cnt", dut.bit_cnt_q, 0);
        check("midrst_rd_addr_seen", dut.rd_addr_seen_q, 0);
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        check("midrst_no_rx_valid", rx_pulses - p, 0);
        check("midrst_state_after", dut.state_q, IDLE);
        check("rx_queue_drained", rx_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
